float_copro_seq: RTL and testbench
==================================

# float_copro_seq

Parametrised successor to the single-shot coprocessor controller. It sequences floating-point operations from the LM32 coprocessor interface through an external combinational datapath (float_copro_dp or a wider equivalent). It adds an asynchronous reset, a ready/valid request queue that buffers operations issued while one is executing, per-opcode latency parameters, a generic data width, and back-to-back issue on result accept.

## Interface
- WIDTH, 32: operand/result width.
- OPW, 11: opcode width.
- T_ADD, 2: cycles of stable datapath inputs for opcode 0 (add); ≥1.
- T_SUB, 2: same for opcode 1 (sub); ≥1.
- T_MUL, 2: same for opcode 2 (mul); ≥1.
- T_DIV, 12: same for opcode 3 (div); ≥1.
- QDEPTH, 2: request queue entries; power of two, ≥1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- copro_valid  in  1  request present.
- copro_ready  out  1  queue can accept; = !full, registered state only, 0 while rst_n low.
- copro_opcode  in  OPW  operation.
- copro_op0, copro_op1  in  WIDTH  operands.
- copro_complete  out  1  result valid, held until accepted.
- copro_accept  in  1  consumer takes result.
- copro_result  out  WIDTH  result, stable while complete=1.
- copro_error  out  1  illegal opcode flag, qualified by complete.
- busy  out  1  FSM not IDLE or queue non-empty.
- dp_opcode  out  OPW  to datapath.
- dp_op0, dp_op1  out  WIDTH  to datapath, held for the whole execution.
- dp_result  in  WIDTH  combinational datapath result.

## Operation
- Push: copro_valid && copro_ready sampled at a clock edge writes {opcode, op0, op1} to the queue tail. Requests are ordered FIFO. There is no fall-through: a push is never visible to the FSM in the same cycle.
- FSM states:
  - IDLE: on an edge with the queue non-empty, pop the head into the exec registers (dp_*), set cnt=1 and go to EXEC.
  - EXEC: on an edge with cnt==T(opcode), latch dp_result into copro_result, set complete=1 and go to DONE. Otherwise cnt++.
  - DONE: hold the result. On an edge with copro_accept=1: clear complete. If the queue is non-empty, pop the next entry with cnt=1 and go to EXEC. Otherwise go to IDLE.
- copro_accept is ignored outside DONE.
- Push and pop on the same edge are allowed; the occupancy count stays unchanged.
- Full queue: copro_ready=0. The requester holds valid and its data; nothing is lost or overwritten.
- cnt width: clog2(max T)+1. Wrap is impossible because cnt is reset on every load.
- Reset (any time, including mid-EXEC or DONE):
  - queue empties, state goes to IDLE, cnt=0;
  - copro_complete=0, copro_result=0, copro_error=0, busy=0;
  - dp_opcode/dp_op0/dp_op1=0;
  - the in-flight operation is discarded.

## Timing
- Handshake at edge E0 into an empty, idle block: exec registers load at E1, and complete rises at edge E(T+1). Latency is T+1 cycles. The datapath sees stable inputs for exactly T cycles.
- Accept on the first complete cycle with the queue non-empty: the next op loads on that edge. Steady-state throughput is one op per T+1 cycles.
- copro_result and copro_error change only on the edge that sets complete, and on reset.

## Configuration
- FLOAT_COPRO_ILLEGAL_TRAP_EN defined: opcodes ≥4 use latency 1. They complete with copro_result=0 and copro_error=1.
- Not defined: opcodes ≥4 use T_DIV latency and return dp_result. copro_error is tied 0.

## Test plan
- Reset and single add (T_ADD=2): after rst_n rises, push op 0 with op0=0x3F800000, op1=0x40000000 at E0. complete rises at E3 with result=0x40400000 (dp model), and stays high until accept.
- Div latency: push op 3 at E0. complete stays 0 through E12 and rises at E13; dp_op0/dp_op1 are constant E1..E13.
- Queue full: with QDEPTH=2 and a div executing, push 2 more ops. copro_ready drops to 0 and a third valid is held. Results return in order, and the second op loads on the accept edge.
- Accept ignored and held result: pulse copro_accept while in EXEC, with no effect. Delay accept 5 cycles after complete; result and complete stay unchanged.
- Reset mid-operation: assert rst_n=0 asynchronously at cnt=5 of a div with 1 entry queued. Outputs go to 0 immediately, and no completion follows after release.
- Illegal opcode 7 with FLOAT_COPRO_ILLEGAL_TRAP_EN: complete at E2 with result=0 and error=1. Without the macro: complete at E13 with error=0.

Source files
------------

// File: rtl/float_copro_seq.sv
// Sequencer between the LM32 coprocessor port and an external combinational FP datapath.
// Optional: FLOAT_COPRO_ILLEGAL_TRAP_EN makes opcodes >= 4 complete in one cycle with an error flag.
module float_copro_seq #(
    parameter int WIDTH  = 32,
    parameter int OPW    = 11,
    parameter int T_ADD  = 2,
    parameter int T_SUB  = 2,
    parameter int T_MUL  = 2,
    parameter int T_DIV  = 12,
    parameter int QDEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             copro_valid,
    output logic             copro_ready,
    input  logic [OPW-1:0]   copro_opcode,
    input  logic [WIDTH-1:0] copro_op0,
    input  logic [WIDTH-1:0] copro_op1,
    output logic             copro_complete,
    input  logic             copro_accept,
    output logic [WIDTH-1:0] copro_result,
    output logic             copro_error,
    output logic             busy,
    output logic [OPW-1:0]   dp_opcode,
    output logic [WIDTH-1:0] dp_op0,
    output logic [WIDTH-1:0] dp_op1,
    input  logic [WIDTH-1:0] dp_result
);
    localparam int TMAX = (T_ADD > T_SUB ? T_ADD : T_SUB) > (T_MUL > T_DIV ? T_MUL : T_DIV)
                        ? (T_ADD > T_SUB ? T_ADD : T_SUB) : (T_MUL > T_DIV ? T_MUL : T_DIV);
    localparam int CW   = $clog2(TMAX) + 1;
    localparam int AW   = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int NW   = $clog2(QDEPTH + 1);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]     count_q;
    logic [OPW-1:0]    q_opc_q [QDEPTH];
    logic [WIDTH-1:0]  q_a_q   [QDEPTH];
    logic [WIDTH-1:0]  q_b_q   [QDEPTH];
    logic              cmp_q;
    logic [WIDTH-1:0]  res_q;
    logic              push, pop, load_res, clr_cmp, q_empty;

    assign q_empty     = (count_q == '0);
    assign copro_ready = rst_n && (count_q != NW'(QDEPTH));
    assign push        = copro_valid && copro_ready;

    function automatic logic [CW-1:0] lat_of(input logic [OPW-1:0] op);
        if (op == OPW'(0))      return CW'(T_ADD);
        else if (op == OPW'(1)) return CW'(T_SUB);
        else if (op == OPW'(2)) return CW'(T_MUL);
        else if (op == OPW'(3)) return CW'(T_DIV);
`ifdef FLOAT_COPRO_ILLEGAL_TRAP_EN
        else                    return CW'(1);
`else
        else                    return CW'(T_DIV);
`endif
    endfunction

    // Queue storage carries no reset; occupancy and pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            q_opc_q[wr_ptr_q] <= copro_opcode;
            q_a_q[wr_ptr_q]   <= copro_op0;
            q_b_q[wr_ptr_q]   <= copro_op1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= (wr_ptr_q == AW'(QDEPTH - 1)) ? '0 : wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= (rd_ptr_q == AW'(QDEPTH - 1)) ? '0 : rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + NW'(1);
                2'b01:   count_q <= count_q - NW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        pop      = 1'b0;
        load_res = 1'b0;
        clr_cmp  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    cnt_d   = CW'(1);
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (cnt_q == lat_of(dp_opcode)) begin
                    load_res = 1'b1;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (copro_accept) begin
                    clr_cmp = 1'b1;
                    if (!q_empty) begin
                        pop     = 1'b1;
                        cnt_d   = CW'(1);
                        state_d = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            cmp_q     <= 1'b0;
            dp_opcode <= '0;
            dp_op0    <= '0;
            dp_op1    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (load_res)     cmp_q <= 1'b1;
            else if (clr_cmp) cmp_q <= 1'b0;
            if (pop) begin
                dp_opcode <= q_opc_q[rd_ptr_q];
                dp_op0    <= q_a_q[rd_ptr_q];
                dp_op1    <= q_b_q[rd_ptr_q];
            end
        end
    end

`ifdef FLOAT_COPRO_ILLEGAL_TRAP_EN
    logic illegal, err_q;
    assign illegal = (dp_opcode > OPW'(3));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q <= '0;
            err_q <= 1'b0;
        end else if (load_res) begin
            res_q <= illegal ? '0 : dp_result;
            err_q <= illegal;
        end
    end
    assign copro_error = err_q;
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        res_q <= '0;
        else if (load_res) res_q <= dp_result;
    end
    assign copro_error = 1'b0;
`endif

    assign copro_complete = cmp_q;
    assign copro_result   = res_q;
    assign busy           = (state_q != IDLE) || !q_empty;
endmodule

// File: tb/tb_float_copro_seq.sv
// Directed bench for float_copro_seq with a behavioural single-precision datapath model.
module tb_float_copro_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        copro_valid = 1'b0, copro_ready, copro_accept = 1'b0;
    logic [10:0] copro_opcode = '0;
    logic [31:0] copro_op0 = '0, copro_op1 = '0;
    logic        copro_complete, copro_error, busy;
    logic [31:0] copro_result, dp_op0, dp_op1, dp_result;
    logic [10:0] dp_opcode;
    int          errors = 0, checks = 0;

    always #5 clk = ~clk;

    float_copro_seq dut (
        .clk(clk), .rst_n(rst_n), .copro_valid(copro_valid), .copro_ready(copro_ready),
        .copro_opcode(copro_opcode), .copro_op0(copro_op0), .copro_op1(copro_op1),
        .copro_complete(copro_complete), .copro_accept(copro_accept),
        .copro_result(copro_result), .copro_error(copro_error), .busy(busy),
        .dp_opcode(dp_opcode), .dp_op0(dp_op0), .dp_op1(dp_op1), .dp_result(dp_result)
    );

    function automatic real f2r(input logic [31:0] f);
        logic [63:0] d;
        d = {f[31], 11'(f[30:23]) + 11'd896, f[22:0], 29'b0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] dp_model(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            11'd0:   return r2f(f2r(a) + f2r(b));
            11'd1:   return r2f(f2r(a) - f2r(b));
            11'd2:   return r2f(f2r(a) * f2r(b));
            11'd3:   return r2f(f2r(a) / f2r(b));
            default: return a ^ b;
        endcase
    endfunction

    assign dp_result = dp_model(dp_opcode, dp_op0, dp_op1);

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        copro_valid  = 1'b1;
        copro_opcode = op;
        copro_op0    = a;
        copro_op1    = b;
    endtask

    task automatic push(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b);
        set_req(op, a, b);
        tick;
        copro_valid = 1'b0;
    endtask

    task automatic accept;
        copro_accept = 1'b1;
        tick;
        copro_accept = 1'b0;
    endtask

    task automatic wait_cmp(input int lim, output int n);
        n = 0;
        while (!copro_complete && n < lim) begin
            tick;
            n++;
        end
        if (!copro_complete) chk("timeout", {63'b0, copro_complete}, 64'd1);
    endtask

    int n;
    int ill_lat;
    logic [31:0] ill_res;
    logic        ill_err;

    initial begin
`ifdef FLOAT_COPRO_ILLEGAL_TRAP_EN
        ill_lat = 2;  ill_res = 32'h0;        ill_err = 1'b1;
`else
        ill_lat = 13; ill_res = 32'h1D3B5977; ill_err = 1'b0;
`endif
        // reset state
        #12;
        chk("rst_ready", copro_ready, 0);
        chk("rst_cmp", copro_complete, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tick;
        chk("idle_ready", copro_ready, 1);
        chk("idle_dp", {dp_opcode, dp_op0}, 0);

        // single add, latency 3
        push(11'd0, 32'h3F800000, 32'h40000000);
        chk("add_busy", busy, 1);
        tick;
        chk("add_load", dp_op0, 32'h3F800000);
        chk("add_e1", copro_complete, 0);
        tick;
        chk("add_e2", copro_complete, 0);
        tick;
        chk("add_e3", copro_complete, 1);
        chk("add_res", copro_result, 32'h40400000);
        chk("add_err", copro_error, 0);
        tick; tick;
        chk("add_hold", {copro_complete, copro_result}, {1'b1, 32'h40400000});
        accept;
        chk("add_acc", copro_complete, 0);
        chk("add_idle", busy, 0);

        // div latency and operand stability
        push(11'd3, 32'h40C00000, 32'h40000000);
        for (int i = 1; i <= 12; i++) begin
            tick;
            chk("div_wait", copro_complete, 0);
            chk("div_ops", {dp_op0, dp_op1}, {32'h40C00000, 32'h40000000});
        end
        tick;
        chk("div_e13", copro_complete, 1);
        chk("div_res", copro_result, 32'h40400000);
        chk("div_ops13", {dp_op0, dp_op1}, {32'h40C00000, 32'h40000000});
        accept;

        // illegal opcode
        push(11'd7, 32'h12345678, 32'h0F0F0F0F);
        wait_cmp(20, n);
        chk("ill_lat", n, ill_lat);
        chk("ill_res", copro_result, ill_res);
        chk("ill_err", copro_error, ill_err);
        accept;
        chk("ill_idle", busy, 0);

        // queue full, ignored accept, delayed accept, ordering
        push(11'd3, 32'h40C00000, 32'h40000000);
        push(11'd2, 32'h40000000, 32'h40400000);
        push(11'd1, 32'h40400000, 32'h3F800000);
        set_req(11'd0, 32'h3F800000, 32'h40000000);
        chk("full_ready", copro_ready, 0);
        tick;
        chk("full_hold", copro_ready, 0);
        accept;
        chk("acc_ignored", copro_complete, 0);
        chk("acc_ign_op", dp_opcode, 3);
        wait_cmp(20, n);
        chk("qa_res", copro_result, 32'h40400000);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("late_hold", {copro_complete, copro_result}, {1'b1, 32'h40400000});
            chk("late_full", copro_ready, 0);
        end
        accept;
        chk("qb_cmp0", copro_complete, 0);
        chk("qb_load", dp_opcode, 2);
        chk("qb_ops", {dp_op0, dp_op1}, {32'h40000000, 32'h40400000});
        chk("qb_ready", copro_ready, 1);
        tick;
        copro_valid = 1'b0;
        wait_cmp(20, n);
        chk("qb_res", copro_result, 32'h40C00000);
        accept;
        chk("qc_load", dp_opcode, 1);
        wait_cmp(20, n);
        chk("qc_res", copro_result, 32'h40000000);
        accept;
        wait_cmp(20, n);
        chk("qd_op", dp_opcode, 0);
        chk("qd_res", copro_result, 32'h40400000);
        accept;
        chk("q_idle", busy, 0);

        // async reset mid-div with one entry queued
        push(11'd3, 32'h40C00000, 32'h40000000);
        push(11'd3, 32'h40000000, 32'h3F800000);
        tick; tick; tick; tick;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_cmp", copro_complete, 0);
        chk("ar_res", copro_result, 0);
        chk("ar_busy", busy, 0);
        chk("ar_ready", copro_ready, 0);
        chk("ar_dp", {dp_opcode, dp_op0, dp_op1}, 0);
        chk("ar_err", copro_error, 0);
        #10;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            chk("ar_quiet", {copro_complete, busy}, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
